polar_averager: RTL
===================

POLAR_AVERAGER -- requirements
Module: polar_averager

Interface
REQ-001 SHALL have parameter LOG2N, default 4, log2 of the window length N (1..8).
REQ-002 SHALL have parameter CORDIC_LAT, default 9, cycles from rectangular input to polar output of the upstream converter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge; one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port strobe_i  input  1  sample strobe, asserted in the cycle X/Y enter the upstream converter.
REQ-006 SHALL have port mag_i  input  17  unsigned magnitude from the converter.
REQ-007 SHALL have port ang_i  input  17  unsigned angle, 0x100 per degree, full circle 0x16800.
REQ-008 SHALL have port clear_i  input  1  discard the partial window.
REQ-009 SHALL have port mag_o  output  17  window-mean magnitude.
REQ-010 SHALL have port ang_o  output  17  window-mean angle, range 0..0x167FF.
REQ-011 SHALL have port valid_o  output  1  result available.
REQ-012 SHALL have port ready_i  input  1  consumer accepts the result when valid_o && ready_i.
REQ-013 SHALL have port overrun_o  output  1  sticky flag: unread result overwritten.

Function
REQ-014 SHALL delay strobe_i by exactly CORDIC_LAT cycles; the delayed strobe qualifies mag_i/ang_i, so a strobe sampled at edge k takes the data sampled at edge k+CORDIC_LAT.
REQ-015 SHALL normalise each qualified ang_i >= 0x16800 by subtracting 0x16800 before use.
REQ-016 SHALL run a window counter 0..N-1 with states IDLE (count 0), ACCUM (count 1..N-1) and FINISH (one cycle).
REQ-017 SHALL, on the first sample of a window, latch ref = angle, set mag_acc = mag and ang_acc = 0.
REQ-018 SHALL, on each later sample, form d = angle - ref, subtract 0x16800 if d > 0xB400, add 0x16800 if d < -0xB400, and add d to an 18+LOG2N-bit signed ang_acc.
REQ-019 SHALL accumulate magnitude in a 17+LOG2N-bit unsigned mag_acc with no overflow possible.
REQ-020 SHALL, in FINISH, compute mag_o = mag_acc >> LOG2N (truncate) and ang = ref + (ang_acc >>> LOG2N) (arithmetic floor); add 0x16800 if ang < 0, subtract it if ang >= 0x16800.
REQ-021 SHALL assert valid_o two cycles after the edge sampling the Nth qualified sample.
REQ-022 SHALL accept qualified samples on every cycle; a sample arriving during FINISH starts the next window without loss.
REQ-023 SHALL hold mag_o/ang_o/valid_o stable until the valid_o && ready_i handshake, then deassert valid_o unless a new result loads in the same cycle.
REQ-024 SHALL, when a new result loads while valid_o=1 and ready_i=0, overwrite the outputs, keep valid_o high and set overrun_o.
REQ-025 SHALL, when a new result loads in the handshake cycle, load it without setting overrun_o.
REQ-026 SHALL, on clear_i, return to IDLE with count 0; a qualified sample in the same cycle becomes sample 1 of a fresh window; the strobe delay line and output register are unaffected.

Reset
REQ-027 SHALL on rst clear mag_o, ang_o, valid_o, overrun_o, counter, accumulators, ref and every strobe delay stage to 0, state IDLE.
REQ-028 SHALL let rst override clear_i, strobe_i and ready_i in the same cycle; a window in progress is discarded.

Structure
REQ-029 SHALL take ANG_FULL = 0x16800, ANG_HALF = 0xB400 and the 17-bit data width from the shared package lockin_pkg.
REQ-030 SHALL implement the strobe delay as the sub-module strobe_delay (parameter DEPTH, shift register of 1-bit stages).

Verification
REQ-031 SHALL cover: LOG2N=2, four samples mag 0x01000 ang 0x02D00 -> mag_o 0x01000, ang_o 0x02D00, valid_o two cycles after the 4th sample.
REQ-032 SHALL cover: angles 0x16700, 0x00100, 0x16700, 0x00100 -> ang_o 0x00000; mags 3, 4, 4, 4 -> mag_o 3.
REQ-033 SHALL cover: a single strobe at cycle 0 with mag_i changing only at cycle CORDIC_LAT=9 -> the cycle-9 value is averaged.
REQ-034 SHALL cover: ready_i held low across two windows -> overrun_o=1 and the second result is presented; a handshake then drops valid_o.
REQ-035 SHALL cover: two samples, clear_i, then four samples mag 0x00800 -> mag_o 0x00800.
REQ-036 SHALL cover: rst asserted in mid-window with valid_o=1 -> all outputs 0 next cycle, and the next full window averages correctly.

Source files
------------

// File: rtl/lockin_pkg.sv
// Shared constants and helpers for the lock-in polar datapath.
// Angles are unsigned, 0x100 per degree, one full turn = 0x16800.
package lockin_pkg;

  localparam int unsigned DW = 17;
  localparam logic [DW-1:0] ANG_FULL = 17'h16800;
  localparam logic [DW-1:0] ANG_HALF = 17'h0B400;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH
  } win_state_t;

  // Fold a converter angle that landed on or past a full turn back into range.
  function automatic logic [DW-1:0] norm_ang(input logic [DW-1:0] a);
    return (a >= ANG_FULL) ? a - ANG_FULL : a;
  endfunction

endpackage

// File: rtl/strobe_delay.sv
// Fixed-length 1-bit delay line aligning the sample strobe with the
// converter output.
module strobe_delay #(
  parameter int unsigned DEPTH = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_sr
      logic [DEPTH-1:0] sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          sr <= '0;
        end else begin
          sr[0] <= d;
          for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/polar_averager.sv
// Averages N = 2**LOG2N polar samples; the angle mean is taken relative to
// the window's first angle so that windows straddling 0/360 degrees average correctly.
module polar_averager
  import lockin_pkg::*;
#(
  parameter int unsigned LOG2N      = 4,
  parameter int unsigned CORDIC_LAT = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe_i,
  input  logic [DW-1:0] mag_i,
  input  logic [DW-1:0] ang_i,
  input  logic          clear_i,
  output logic [DW-1:0] mag_o,
  output logic [DW-1:0] ang_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overrun_o
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned AW = 18 + LOG2N;
  localparam int unsigned MW = 17 + LOG2N;
  localparam int unsigned CW = LOG2N + 1;
  localparam logic signed [19:0] FULL_S = signed'({3'b000, ANG_FULL});
  localparam logic signed [19:0] HALF_S = signed'({3'b000, ANG_HALF});

  logic                 q_strobe;
  logic [DW-1:0]        ang_n;
  win_state_t           state;
  logic [CW-1:0]        count;
  logic [DW-1:0]        ref_ang;
  logic [MW-1:0]        mag_acc;
  logic signed [AW-1:0] ang_acc;
  logic signed [AW-1:0] ang_mean;
  logic signed [19:0]   d_raw, d_wrap, ang_sum, fin_ang;
  logic                 res_vld;
  logic [DW-1:0]        res_mag, res_ang;

  strobe_delay #(.DEPTH(CORDIC_LAT)) u_strobe_delay (
    .clk (clk),
    .rst (rst),
    .d   (strobe_i),
    .q   (q_strobe)
  );

  assign ang_n = norm_ang(ang_i);

  always_comb begin
    d_raw  = signed'({3'b000, ang_n}) - signed'({3'b000, ref_ang});
    d_wrap = d_raw;
    if (d_raw > HALF_S)       d_wrap = d_raw - FULL_S;
    else if (d_raw < -HALF_S) d_wrap = d_raw + FULL_S;

    ang_mean = ang_acc >>> LOG2N;
    ang_sum  = signed'({3'b000, ref_ang}) + 20'(ang_mean);
    fin_ang  = ang_sum;
    if (ang_sum < 0)            fin_ang = ang_sum + FULL_S;
    else if (ang_sum >= FULL_S) fin_ang = ang_sum - FULL_S;
  end

  // Result is snapshotted in FINISH so a sample arriving in that same cycle
  // can restart the accumulators without disturbing the finished window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      ref_ang <= '0;
      mag_acc <= '0;
      ang_acc <= '0;
      res_vld <= 1'b0;
      res_mag <= '0;
      res_ang <= '0;
    end else begin
      res_vld <= (state == FINISH);
      if (state == FINISH) begin
        res_mag <= DW'(mag_acc >> LOG2N);
        res_ang <= fin_ang[DW-1:0];
      end

      if (q_strobe) begin
        if (clear_i || state != ACCUM) begin
          ref_ang <= ang_n;
          mag_acc <= MW'(mag_i);
          ang_acc <= '0;
          if (N == 1) begin
            state <= FINISH;
            count <= '0;
          end else begin
            state <= ACCUM;
            count <= CW'(1);
          end
        end else begin
          mag_acc <= mag_acc + MW'(mag_i);
          ang_acc <= ang_acc + AW'(d_wrap);
          if (count == CW'(N - 1)) begin
            state <= FINISH;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
      end else if (clear_i || state == FINISH) begin
        state <= IDLE;
        count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_o     <= '0;
      ang_o     <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (res_vld) begin
      mag_o   <= res_mag;
      ang_o   <= res_ang;
      valid_o <= 1'b1;
      if (valid_o && !ready_i) overrun_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
